// File: rtl/ricevitore_seriale_pkg.sv
// Shared definitions for the 8N1 serial receiver: frame size, line idle level
// and the state encodings of the receive and handshake FSMs.
package ricevitore_seriale_pkg;

  localparam int unsigned FRAME_BITS = 8;
  localparam logic        LINE_IDLE  = 1'b1;

  typedef enum logic [1:0] {
    RX_IDLE,
    RX_START,
    RX_DATA,
    RX_STOP
  } rx_state_t;

  typedef enum logic [1:0] {
    H0,
    H1,
    H2
  } hs_state_t;

endpackage

// File: rtl/ricevitore_seriale_sincronizzatore.sv
// Two-stage D flip-flop synchronizer for an asynchronous input; both stages
// are set to the idle line level on reset.
module sincronizzatore
  import ricevitore_seriale_pkg::*;
(
  input  logic clock,
  input  logic reset,
  input  logic d,
  output logic q
);

  logic meta;

  always_ff @(posedge clock) begin
    if (reset) begin
      meta <= LINE_IDLE;
      q    <= LINE_IDLE;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/ricevitore_seriale.sv
// 8N1 serial receiver: synchronizes rxd, recovers a frame and hands the byte
// to the consumer over the dav_/rfd four-phase handshake.
module ricevitore_seriale
  import ricevitore_seriale_pkg::*;
#(
  parameter int unsigned BIT_TIME = 16
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       rxd,
  input  logic       rfd,
  // the received byte; `byte` is a reserved word in SystemVerilog
  output logic [7:0] rx_byte,
  output logic       dav_,
  output logic       ferr,
  output logic       ovr
);

  localparam int unsigned CW = $clog2(BIT_TIME);
  localparam logic [CW-1:0] CNT_HALF = CW'(BIT_TIME / 2 - 1);
  localparam logic [CW-1:0] CNT_FULL = CW'(BIT_TIME - 1);
  localparam logic [3:0]    LAST_BIT = 4'(FRAME_BITS - 1);

  logic rxd_s;

  rx_state_t rx_state, rx_next;
  hs_state_t hs_state, hs_next;

  logic [CW-1:0] cnt, cnt_next;
  logic [3:0]    nbit, nbit_next;
  logic [7:0]    sr, sr_next;
  logic [7:0]    byte_next;
  logic          dav_next, ovr_next;
  logic          deliver, frame_err;

  sincronizzatore u_sync (
    .clock (clock),
    .reset (reset),
    .d     (rxd),
    .q     (rxd_s)
  );

  // Receive FSM: cnt free-runs inside a bit and reloads at every sample point.
  always_comb begin
    rx_next   = rx_state;
    cnt_next  = cnt + 1'b1;
    nbit_next = nbit;
    sr_next   = sr;
    deliver   = 1'b0;
    frame_err = 1'b0;
    case (rx_state)
      RX_IDLE: begin
        cnt_next = cnt;
        if (rxd_s != LINE_IDLE) begin
          cnt_next = '0;
          rx_next  = RX_START;
        end
      end
      RX_START: begin
        if (cnt == CNT_HALF) begin
          cnt_next = '0;
          if (rxd_s != LINE_IDLE) begin
            nbit_next = '0;
            rx_next   = RX_DATA;
          end else begin
            rx_next = RX_IDLE;
          end
        end
      end
      RX_DATA: begin
        if (cnt == CNT_FULL) begin
          cnt_next  = '0;
          sr_next   = {rxd_s, sr[7:1]};
          nbit_next = nbit + 4'd1;
          if (nbit == LAST_BIT) rx_next = RX_STOP;
        end
      end
      RX_STOP: begin
        if (cnt == CNT_FULL) begin
          cnt_next = '0;
          rx_next  = RX_IDLE;
          if (rxd_s == LINE_IDLE) deliver   = 1'b1;
          else                    frame_err = 1'b1;
        end
      end
      default: rx_next = RX_IDLE;
    endcase
  end

  // Handshake FSM; a delivery outside H0 (including H2 seeing rfd=1) is an overrun.
  always_comb begin
    hs_next   = hs_state;
    byte_next = rx_byte;
    dav_next  = dav_;
    ovr_next  = ovr | (deliver && (hs_state != H0));
    case (hs_state)
      H0: begin
        if (deliver) begin
          byte_next = sr;
          dav_next  = 1'b0;
          hs_next   = H1;
        end
      end
      H1: begin
        if (!rfd) begin
          dav_next = 1'b1;
          hs_next  = H2;
        end
      end
      H2: begin
        if (rfd) hs_next = H0;
      end
      default: hs_next = H0;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      rx_state <= RX_IDLE;
      hs_state <= H0;
      cnt      <= '0;
      nbit     <= '0;
      sr       <= '0;
      rx_byte  <= '0;
      dav_     <= 1'b1;
      ferr     <= 1'b0;
      ovr      <= 1'b0;
    end else begin
      rx_state <= rx_next;
      hs_state <= hs_next;
      cnt      <= cnt_next;
      nbit     <= nbit_next;
      sr       <= sr_next;
      rx_byte  <= byte_next;
      dav_     <= dav_next;
      ferr     <= frame_err;
      ovr      <= ovr_next;
    end
  end

endmodule

// File: tb/tb_ricevitore_seriale.sv
// Self-checking bench for ricevitore_seriale: directed frame table, hand-written
// corner sequences and random frames checked against a consumer-level model.
module tb_ricevitore_seriale;

  localparam int BT = 16;

  logic       clock = 1'b0;
  logic       reset;
  logic       rxd;
  logic       rfd;
  logic [7:0] rx_byte;
  logic       dav_;
  logic       ferr;
  logic       ovr;

  int checks = 0;
  int errors = 0;

  always #5 clock = ~clock;

  ricevitore_seriale #(.BIT_TIME(BT)) dut (
    .clock   (clock),
    .reset   (reset),
    .rxd     (rxd),
    .rfd     (rfd),
    .rx_byte (rx_byte),
    .dav_    (dav_),
    .ferr    (ferr),
    .ovr     (ovr)
  );

  // Outputs observed around one frame; edges are counted from the edge that
  // first captures the start bit (stop sample lands on edge 154 with BT=16).
  typedef struct {
    logic        dav_pre;
    logic        ovr_pre;
    logic        dav_at;
    logic        ovr_at;
    logic [7:0]  byte_at;
    int          nferr;
    logic [10:0] rst_vals;
  } obs_t;

  typedef struct {
    logic [7:0] data;
    bit         stop;
    bit         ack;
    logic       dav_pre;
    logic       dav_at;
    logic [7:0] byte_at;
    int         nferr;
    logic       ovr_at;
  } vec_t;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic hard_reset();
    @(negedge clock);
    reset = 1'b1;
    @(posedge clock);
    @(negedge clock);
    reset = 1'b0;
  endtask

  task automatic send_frame(input logic [7:0] d, input bit stop, input int stop_len,
                            input int gap, input int rst_at, output obs_t o);
    logic [9:0] bits;
    int total;
    bits       = {stop, d, 1'b0};
    o.dav_pre  = 1'bx;
    o.ovr_pre  = 1'bx;
    o.dav_at   = 1'bx;
    o.ovr_at   = 1'bx;
    o.byte_at  = 8'hxx;
    o.nferr    = 0;
    o.rst_vals = 'x;
    total = 9 * BT + stop_len + (stop ? gap : gap + BT);
    for (int e = 0; e < total; e++) begin
      @(negedge clock);
      if (e < 9 * BT)                 rxd = bits[e / BT];
      else if (e < 9 * BT + stop_len) rxd = stop;
      else                            rxd = 1'b1;
      reset = (e == rst_at);
      @(posedge clock);
      #1;
      if (e == 153) begin
        o.dav_pre = dav_;
        o.ovr_pre = ovr;
      end
      if (e == 154) begin
        o.dav_at  = dav_;
        o.ovr_at  = ovr;
        o.byte_at = rx_byte;
      end
      if (e == rst_at) o.rst_vals = {dav_, rx_byte, ferr, ovr};
      if (ferr) o.nferr++;
    end
    reset = 1'b0;
  endtask

  task automatic ack(input logic exp_dav_before);
    repeat (5) begin
      @(negedge clock);
      rfd = 1'b1;
      @(posedge clock);
      #1;
    end
    chk("dav_hold", dav_, exp_dav_before);
    @(negedge clock);
    rfd = 1'b0;
    @(posedge clock);
    #1;
    chk("dav_rise", dav_, 1'b1);
    @(negedge clock);
    rfd = 1'b1;
    @(posedge clock);
    #1;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: time limit reached, got no finish expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t tbl[5];
    obs_t o;
    int   quiet;
    logic       m_pending;
    logic [7:0] m_shown;
    logic       m_ovr;
    logic [7:0] rd;
    bit         rstop;
    bit         rack;

    tbl[0] = '{8'hA5, 1'b1, 1'b1, 1'b1, 1'b0, 8'hA5, 0, 1'b0};
    tbl[1] = '{8'h3C, 1'b1, 1'b1, 1'b1, 1'b0, 8'h3C, 0, 1'b0};
    tbl[2] = '{8'h55, 1'b0, 1'b0, 1'b1, 1'b1, 8'h3C, 1, 1'b0};
    tbl[3] = '{8'h11, 1'b1, 1'b0, 1'b1, 1'b0, 8'h11, 0, 1'b0};
    tbl[4] = '{8'h22, 1'b1, 1'b0, 1'b0, 1'b0, 8'h11, 0, 1'b1};

    reset = 1'b1;
    rxd   = 1'b1;
    rfd   = 1'b1;
    repeat (3) @(posedge clock);
    @(negedge clock);
    reset = 1'b0;
    chk("reset_outputs", {dav_, rx_byte, ferr, ovr}, {1'b1, 8'h00, 1'b0, 1'b0});

    // Directed frames: clean, handshake, framing error, overrun.
    for (int i = 0; i < 5; i++) begin
      send_frame(tbl[i].data, tbl[i].stop, BT, 4, -1, o);
      chk($sformatf("tbl%0d_dav_pre", i), o.dav_pre, tbl[i].dav_pre);
      chk($sformatf("tbl%0d_dav_at", i),  o.dav_at,  tbl[i].dav_at);
      chk($sformatf("tbl%0d_byte", i),    o.byte_at, tbl[i].byte_at);
      chk($sformatf("tbl%0d_ferr", i),    o.nferr,   tbl[i].nferr);
      chk($sformatf("tbl%0d_ovr", i),     o.ovr_at,  tbl[i].ovr_at);
      if (tbl[i].ack) ack(tbl[i].dav_at);
    end

    // Reset during data bit 4 of 0xFF with a pending handshake and ovr set.
    send_frame(8'hFF, 1'b1, BT, 4, 88, o);
    chk("midrst_values", o.rst_vals, {1'b1, 8'h00, 1'b0, 1'b0});
    chk("midrst_no_dav", o.dav_at, 1'b1);
    chk("midrst_no_ferr", o.nferr, 0);
    send_frame(8'h81, 1'b1, BT, 4, -1, o);
    chk("after_rst_dav", {o.dav_pre, o.dav_at}, 2'b10);
    chk("after_rst_byte", o.byte_at, 8'h81);
    chk("after_rst_ovr", o.ovr_at, 1'b0);
    ack(1'b0);

    // Short low pulse on the line must be rejected silently.
    quiet = 0;
    for (int c = 0; c < 44; c++) begin
      @(negedge clock);
      rxd = (c < 4) ? 1'b0 : 1'b1;
      @(posedge clock);
      #1;
      if (!dav_ || ferr || ovr) quiet++;
    end
    chk("glitch_quiet", quiet, 0);
    send_frame(8'h5A, 1'b1, BT, 4, -1, o);
    chk("post_glitch_byte", {o.dav_at, o.byte_at}, {1'b0, 8'h5A});
    ack(1'b0);

    // Stop bit cut short, next start bit right behind the stop sample.
    send_frame(8'hE7, 1'b1, 9, 0, -1, o);
    send_frame(8'h18, 1'b1, BT, 4, -1, o);
    chk("b2b_pending", {o.dav_pre, o.ovr_pre}, 2'b00);
    chk("b2b_ovr", o.ovr_at, 1'b1);
    chk("b2b_byte", o.byte_at, 8'hE7);

    // Random frames and consumer behaviour against a consumer-level model.
    hard_reset();
    m_pending = 1'b0;
    m_shown   = 8'h00;
    m_ovr     = 1'b0;
    for (int n = 0; n < 16; n++) begin
      rd    = 8'($urandom);
      rstop = ($urandom_range(0, 3) != 0);
      rack  = ($urandom_range(0, 1) != 0);
      send_frame(rd, rstop, BT, $urandom_range(0, 6), -1, o);
      chk($sformatf("rnd%0d_dav_pre", n), o.dav_pre, !m_pending);
      chk($sformatf("rnd%0d_ovr_pre", n), o.ovr_pre, m_ovr);
      if (rstop) begin
        if (m_pending) m_ovr = 1'b1;
        else begin
          m_shown   = rd;
          m_pending = 1'b1;
        end
      end
      chk($sformatf("rnd%0d_dav_at", n), o.dav_at, !m_pending);
      chk($sformatf("rnd%0d_byte", n), o.byte_at, m_shown);
      chk($sformatf("rnd%0d_ovr", n), o.ovr_at, m_ovr);
      chk($sformatf("rnd%0d_ferr", n), o.nferr, rstop ? 0 : 1);
      if (rack) begin
        ack(!m_pending);
        m_pending = 1'b0;
      end
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
